// File: rtl/seg_display_scheduler_pkg.sv
// Shared constants and types for the seven-segment display scheduler.
package seg_sched_pkg;

  localparam int DIGIT_W          = 4;
  localparam int NUM_DIGITS       = 8;
  localparam int WORD_W           = DIGIT_W * NUM_DIGITS;
  localparam int DEF_HOLD_CYCLES  = 100_000_000;
  localparam int DEF_BLANK_CYCLES = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_BLANK = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester-side valid/ready bundle; requester i's word sits at [32*i+31:32*i].
interface seg_display_scheduler_if
  import seg_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [WORD_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/seg_display_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter
  import seg_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Scan upward from the slot after the previous owner; the first hit wins.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s     = ID_W'((int'(last_grant_i) + i) % NUM_REQ);
      hit_s     = req_i[idx_s] & ~any_req_o;
      grant_o   = hit_s ? idx_s : grant_o;
      any_req_o = any_req_o | req_i[idx_s];
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares one 8-digit display among NUM_REQ requesters, round-robin,
// with a dark gap between different owners.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  seg_display_scheduler_if.slave     req_if,
  output logic [WORD_W-1:0]          disp_encoded_o,
  output logic                       disp_blank_o,
  output logic [$clog2(NUM_REQ)-1:0] active_id_o,
  output logic                       busy_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE_LSB  = NUM_REQ'(1);
  localparam logic NO_GAP = (BLANK_CYCLES == 0);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ID_W-1:0]     grant_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [NUM_REQ-1:0]  ready_q;
  logic [WORD_W-1:0]   enc_q;
  logic                blank_q;
  logic [ID_W-1:0]     active_q;
  logic                busy_q;

  logic [ID_W-1:0]     arb_grant_s;
  logic                any_req_s;
  logic [WORD_W-1:0]   req_words_s [NUM_REQ];
  logic [CNT_W-1:0]    cnt_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign req_words_s[gi] = req_if.req_data[gi*WORD_W +: WORD_W];
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (req_if.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant_s),
    .any_req_o    (any_req_s)
  );

  // Scheduler FSM; every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      ready_q      <= '0;
      enc_q        <= '0;
      blank_q      <= 1'b1;
      active_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          blank_q <= 1'b1;
          busy_q  <= 1'b0;
          if (any_req_s) begin
            grant_q <= arb_grant_s;
            ready_q <= ONE_LSB << arb_grant_s;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          enc_q        <= req_words_s[grant_q];
          active_q     <= grant_q;
          last_grant_q <= grant_q;
          cnt_q        <= '0;
          blank_q      <= 1'b0;
          state_q      <= ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == HOLD_LAST) begin
            if (!any_req_s) begin
              enc_q   <= '0;
              blank_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if ((arb_grant_s == active_q) || NO_GAP) begin
              // Same owner again (or no gap configured): reload with the display lit.
              grant_q <= arb_grant_s;
              ready_q <= ONE_LSB << arb_grant_s;
              state_q <= ST_LOAD;
            end else begin
              cnt_q   <= '0;
              blank_q <= 1'b1;
              state_q <= ST_BLANK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            if (any_req_s) begin
              grant_q <= arb_grant_s;
              ready_q <= ONE_LSB << arb_grant_s;
              state_q <= ST_LOAD;
            end else begin
              enc_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready = ready_q;
  assign disp_encoded_o   = enc_q;
  assign disp_blank_o     = blank_q;
  assign active_id_o      = active_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed scenario tasks plus a randomized run against a timeline reference model.
module tb_seg_display_scheduler;

  localparam int N = 4;
  localparam int H = 8;
  localparam int B = 2;
  localparam int K = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [31:0] enc0, enc1;
  logic        blank0, blank1, busy0, busy1;
  logic [1:0]  aid0, aid1;

  seg_display_scheduler_if #(.NUM_REQ(N)) if0 (), if1 ();

  seg_display_scheduler #(.NUM_REQ(N), .HOLD_CYCLES(H), .BLANK_CYCLES(B)) u_dut0 (
    .clk(clk), .reset(reset), .req_if(if0),
    .disp_encoded_o(enc0), .disp_blank_o(blank0), .active_id_o(aid0), .busy_o(busy0));

  seg_display_scheduler #(.NUM_REQ(N), .HOLD_CYCLES(H), .BLANK_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req_if(if1),
    .disp_encoded_o(enc1), .disp_blank_o(blank1), .active_id_o(aid1), .busy_o(busy1));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first valid index above 'last', wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic test_reset;
    if0.req_valid = '0; if0.req_data = '0;
    if1.req_valid = '0; if1.req_data = '0;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (blank0 !== 1'b1) begin errors++; $display("FAIL rst_blank0 got %b want 1", blank0); end
    checks++; if (enc0 !== 32'h0) begin errors++; $display("FAIL rst_enc0 got %h want 0", enc0); end
    checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready0 got %b want 0000", if0.req_ready); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b want 0", busy0); end
    checks++; if (aid0 !== 2'd0) begin errors++; $display("FAIL rst_aid0 got %0d want 0", aid0); end
    checks++; if (blank1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_dut1 got blank=%b busy=%b want 1/0", blank1, busy1); end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (busy0 !== 1'b0 || blank0 !== 1'b1 || if0.req_ready !== 4'b0000 || enc0 !== 32'h0) begin
        errors++; $display("FAIL idle_stay k=%0d got busy=%b blank=%b ready=%b enc=%h", k, busy0, blank0, if0.req_ready, enc0);
      end
    end
  endtask

  task automatic test_hold_same;
    if0.req_data[2*32 +: 32] = 32'h1234_5678;
    if0.req_valid[2] = 1'b1;
    tick();
    checks++; if (if0.req_ready !== 4'b0100) begin errors++; $display("FAIL hold_ready1 got %b want 0100", if0.req_ready); end
    checks++; if (busy0 !== 1'b1 || blank0 !== 1'b1) begin errors++; $display("FAIL hold_load1 got busy=%b blank=%b want 1/1", busy0, blank0); end
    for (int k = 0; k < H; k++) begin
      tick();
      checks++;
      if (enc0 !== 32'h1234_5678 || blank0 !== 1'b0 || aid0 !== 2'd2 || if0.req_ready !== 4'b0000) begin
        errors++; $display("FAIL hold_show k=%0d got enc=%h blank=%b aid=%0d ready=%b", k, enc0, blank0, aid0, if0.req_ready);
      end
    end
    tick();
    checks++; if (if0.req_ready !== 4'b0100) begin errors++; $display("FAIL hold_reload got %b want 0100", if0.req_ready); end
    checks++; if (blank0 !== 1'b0 || enc0 !== 32'h1234_5678) begin errors++; $display("FAIL hold_lit got blank=%b enc=%h want 0/12345678", blank0, enc0); end
    if0.req_valid[2] = 1'b0;
    repeat (H) tick();
    tick();
    checks++; if (blank0 !== 1'b1 || enc0 !== 32'h0 || busy0 !== 1'b0) begin errors++; $display("FAIL hold_idle got blank=%b enc=%h busy=%b", blank0, enc0, busy0); end
  endtask

  task automatic test_drop_req3;
    if0.req_data[3*32 +: 32] = 32'hDEAD_BEEF;
    if0.req_valid[3] = 1'b1;
    tick();
    checks++; if (if0.req_ready !== 4'b1000) begin errors++; $display("FAIL drop_ready got %b want 1000", if0.req_ready); end
    if0.req_valid[3] = 1'b0;
    for (int k = 0; k < H; k++) begin
      tick();
      checks++;
      if (enc0 !== 32'hDEAD_BEEF || blank0 !== 1'b0 || aid0 !== 2'd3) begin
        errors++; $display("FAIL drop_show k=%0d got enc=%h blank=%b aid=%0d", k, enc0, blank0, aid0);
      end
    end
    tick();
    checks++;
    if (blank0 !== 1'b1 || enc0 !== 32'h0 || busy0 !== 1'b0 || if0.req_ready !== 4'b0000) begin
      errors++; $display("FAIL drop_idle got blank=%b enc=%h busy=%b ready=%b", blank0, enc0, busy0, if0.req_ready);
    end
  endtask

  task automatic test_alternate;
    logic [31:0] word;
    logic [3:0]  want_rdy;
    int          nshow;
    if0.req_data[0 +: 32]  = 32'hAAAA_AAAA;
    if0.req_data[32 +: 32] = 32'hBBBB_BBBB;
    if0.req_valid = 4'b0011;
    tick();
    checks++; if (if0.req_ready !== 4'b0001) begin errors++; $display("FAIL alt_first got %b want 0001", if0.req_ready); end
    for (int w = 0; w < 4; w++) begin
      word  = (w % 2 == 0) ? 32'hAAAA_AAAA : 32'hBBBB_BBBB;
      nshow = (w == 3) ? 4 : H;
      for (int k = 0; k < nshow; k++) begin
        tick();
        checks++;
        if (enc0 !== word || blank0 !== 1'b0 || aid0 !== 2'(w % 2)) begin
          errors++; $display("FAIL alt_show w=%0d k=%0d got enc=%h blank=%b aid=%0d", w, k, enc0, blank0, aid0);
        end
      end
      if (w < 3) begin
        for (int k = 0; k < B; k++) begin
          tick();
          checks++;
          if (blank0 !== 1'b1 || busy0 !== 1'b1 || if0.req_ready !== 4'b0000) begin
            errors++; $display("FAIL alt_blank w=%0d k=%0d got blank=%b busy=%b ready=%b", w, k, blank0, busy0, if0.req_ready);
          end
        end
        tick();
        want_rdy = 4'b0001 << ((w + 1) % 2);
        checks++;
        if (if0.req_ready !== want_rdy || blank0 !== 1'b1) begin
          errors++; $display("FAIL alt_load w=%0d got ready=%b blank=%b want %b/1", w, if0.req_ready, blank0, want_rdy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_show;
    reset = 1'b1;
    tick();
    checks++;
    if (blank0 !== 1'b1 || enc0 !== 32'h0 || busy0 !== 1'b0 || if0.req_ready !== 4'b0000 || aid0 !== 2'd0) begin
      errors++; $display("FAIL rstmid_idle got blank=%b enc=%h busy=%b ready=%b aid=%0d", blank0, enc0, busy0, if0.req_ready, aid0);
    end
    reset = 1'b0;
    tick();
    checks++; if (if0.req_ready !== 4'b0001 || busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_grant got ready=%b busy=%b want 0001/1", if0.req_ready, busy0); end
    if0.req_valid = 4'b0000;
    for (int k = 0; k < H; k++) begin
      tick();
      checks++;
      if (enc0 !== 32'hAAAA_AAAA || aid0 !== 2'd0) begin
        errors++; $display("FAIL rstmid_show k=%0d got enc=%h aid=%0d", k, enc0, aid0);
      end
    end
    tick();
    checks++; if (busy0 !== 1'b0 || blank0 !== 1'b1) begin errors++; $display("FAIL rstmid_end got busy=%b blank=%b", busy0, blank0); end
  endtask

  task automatic test_no_blank;
    logic [31:0] word;
    logic [3:0]  want_rdy;
    int          own;
    if1.req_data[0 +: 32]      = 32'h0F0F_0F0F;
    if1.req_data[2*32 +: 32]   = 32'h2222_2222;
    if1.req_valid = 4'b0101;
    tick();
    checks++; if (if1.req_ready !== 4'b0001) begin errors++; $display("FAIL nb_first got %b want 0001", if1.req_ready); end
    for (int w = 0; w < 4; w++) begin
      own  = (w % 2 == 0) ? 0 : 2;
      word = (own == 0) ? 32'h0F0F_0F0F : 32'h2222_2222;
      for (int k = 0; k < H; k++) begin
        tick();
        checks++;
        if (enc1 !== word || blank1 !== 1'b0 || aid1 !== 2'(own)) begin
          errors++; $display("FAIL nb_show w=%0d k=%0d got enc=%h blank=%b aid=%0d", w, k, enc1, blank1, aid1);
        end
      end
      if (w < 3) begin
        tick();
        want_rdy = (own == 0) ? 4'b0100 : 4'b0001;
        checks++;
        if (if1.req_ready !== want_rdy || blank1 !== 1'b0) begin
          errors++; $display("FAIL nb_load w=%0d got ready=%b blank=%b want %b/0", w, if1.req_ready, blank1, want_rdy);
        end
        if (w == 2) if1.req_valid = 4'b0000;
      end
    end
    tick();
    checks++; if (blank1 !== 1'b1 || busy1 !== 1'b0 || enc1 !== 32'h0) begin errors++; $display("FAIL nb_idle got blank=%b busy=%b enc=%h", blank1, busy1, enc1); end
  endtask

  task automatic test_random;
    if0.req_valid = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    cyc = 0;
    fork
      begin : drv
        logic [N-1:0] seen;
        for (int c = 0; c < K; c++) begin
          @(negedge clk);
          seen = if0.req_ready;
          @(posedge clk);
          #1;
          for (int i = 0; i < N; i++) begin
            if (if0.req_valid[i] && seen[i]) begin
              if ($urandom_range(0, 1) == 0) if0.req_valid[i] = 1'b0;
              else if0.req_data[i*32 +: 32] = $urandom;
            end else if (!if0.req_valid[i] && $urandom_range(0, 5) == 0) begin
              if0.req_data[i*32 +: 32] = $urandom;
              if0.req_valid[i] = 1'b1;
            end
          end
          cyc = c + 1;
        end
      end
      begin : mdl
        int          last, own, win;
        logic [31:0] word;
        logic        pb, chk_enc;
        logic [N-1:0] v;
        last = N - 1; own = 0; word = '0; chk_enc = 1'b1; pb = 1'b1;
        while (cyc < K) begin
          @(negedge clk);
          checks++;
          if (blank0 !== 1'b1 || busy0 !== 1'b0 || if0.req_ready !== 4'b0000 || (chk_enc && enc0 !== 32'h0)) begin
            errors++; $display("FAIL rnd_idle t=%0t got blank=%b busy=%b ready=%b enc=%h", $time, blank0, busy0, if0.req_ready, enc0);
          end
          v   = if0.req_valid;
          win = pick(v, last);
          pb  = 1'b1;
          while (win >= 0 && cyc < K) begin
            @(negedge clk);
            checks++;
            if (if0.req_ready !== (4'b0001 << win) || busy0 !== 1'b1 || blank0 !== pb) begin
              errors++; $display("FAIL rnd_load t=%0t got ready=%b busy=%b blank=%b want id %0d blank %b", $time, if0.req_ready, busy0, blank0, win, pb);
            end
            word = if0.req_data[win*32 +: 32];
            own  = win;
            last = win;
            for (int k = 0; k < H; k++) begin
              @(negedge clk);
              checks++;
              if (enc0 !== word || blank0 !== 1'b0 || aid0 !== 2'(own) || busy0 !== 1'b1 || if0.req_ready !== 4'b0000) begin
                errors++; $display("FAIL rnd_show t=%0t got enc=%h blank=%b aid=%0d ready=%b want %h id %0d", $time, enc0, blank0, aid0, if0.req_ready, word, own);
              end
              v = if0.req_valid;
            end
            win = pick(v, last);
            if (win < 0) begin
              chk_enc = 1'b1;
            end else if (win == own) begin
              pb = 1'b0;
            end else begin
              for (int k = 0; k < B; k++) begin
                @(negedge clk);
                checks++;
                if (blank0 !== 1'b1 || busy0 !== 1'b1 || if0.req_ready !== 4'b0000 || aid0 !== 2'(own)) begin
                  errors++; $display("FAIL rnd_blank t=%0t got blank=%b busy=%b ready=%b aid=%0d", $time, blank0, busy0, if0.req_ready, aid0);
                end
                v = if0.req_valid;
              end
              win     = pick(v, last);
              pb      = 1'b1;
              chk_enc = 1'b0;
            end
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_hold_same();
    test_drop_req3();
    test_alternate();
    test_reset_mid_show();
    test_no_blank();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
